// File: rtl/max31855_emu.sv
// MAX31855 SPI slave emulator: 32-bit frame, pin edges act 3 SYSCLK later, no backpressure (master paces SPI_CLK).
// Define MAX31855_EMU_CONV_EN to make visible data update only when an emulated conversion completes.
module max31855_emu #(
  parameter int CONV_CYCLES = 1000
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst_n,
  input  logic        i_spi_clk,
  input  logic        i_spi_cs,
  output logic        o_spi_miso,
  output logic        o_spi_miso_oe,
  input  logic [13:0] i_temperature_tc,
  input  logic [11:0] i_temperature_ic,
  input  logic        i_fault_oc,
  input  logic        i_fault_scg,
  input  logic        i_fault_scv,
  input  logic        i_load,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_frame_abort
);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t      r_state;
  logic [31:0] r_pend;
  logic [31:0] r_sr;
  logic [5:0]  r_bit_cnt;
  logic        r_cs_s1, r_cs_s2, r_cs_d;
  logic        r_sck_s1, r_sck_s2, r_sck_d;
  logic [31:0] w_vis;
  logic [31:0] w_load_word;
  logic        w_cs_fall, w_cs_rise, w_sck_fall;

  // Reset to 0 so a CS held low through reset release never looks like a falling edge.
  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst_n) begin
      r_cs_s1  <= 1'b0;
      r_cs_s2  <= 1'b0;
      r_cs_d   <= 1'b0;
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_d  <= 1'b0;
    end else begin
      r_cs_s1  <= i_spi_cs;
      r_cs_s2  <= r_cs_s1;
      r_cs_d   <= r_cs_s2;
      r_sck_s1 <= i_spi_clk;
      r_sck_s2 <= r_sck_s1;
      r_sck_d  <= r_sck_s2;
    end
  end

  assign w_cs_fall  = r_cs_d & ~r_cs_s2;
  assign w_cs_rise  = ~r_cs_d & r_cs_s2;
  assign w_sck_fall = r_sck_d & ~r_sck_s2;

  assign w_load_word = {i_temperature_tc, 1'b0, (i_fault_oc | i_fault_scg | i_fault_scv),
                        i_temperature_ic, 1'b0, i_fault_scv, i_fault_scg, i_fault_oc};

  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst_n) begin
      r_pend <= '0;
    end else if (i_load) begin
      r_pend <= w_load_word;
    end
  end

`ifdef MAX31855_EMU_CONV_EN
  logic [31:0] r_vis;
  logic [19:0] r_conv_cnt;
  logic        r_conv_act;

  // A frame start cancels the running conversion; the frame end restarts it.
  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst_n) begin
      r_vis      <= '0;
      r_conv_cnt <= '0;
      r_conv_act <= 1'b1;
    end else if (w_cs_rise && r_state == ST_SHIFT) begin
      r_conv_cnt <= '0;
      r_conv_act <= 1'b1;
    end else if (w_cs_fall && r_state == ST_IDLE) begin
      r_conv_cnt <= '0;
      r_conv_act <= 1'b0;
    end else if (r_conv_act) begin
      if (r_conv_cnt == 20'(CONV_CYCLES - 1)) begin
        r_vis      <= r_pend;
        r_conv_act <= 1'b0;
      end else begin
        r_conv_cnt <= r_conv_cnt + 20'd1;
      end
    end
  end

  assign w_vis = r_vis;
`else
  logic [19:0] w_unused_conv;
  assign w_unused_conv = 20'(CONV_CYCLES);
  assign w_vis         = r_pend;
`endif

  always_ff @(posedge i_sysclk) begin
    if (!i_sysrst_n) begin
      r_state       <= ST_IDLE;
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      o_spi_miso    <= 1'b0;
      o_spi_miso_oe <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_abort <= 1'b0;
    end else begin
      o_frame_done  <= 1'b0;
      o_frame_abort <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state       <= ST_SHIFT;
            r_sr          <= w_vis;
            r_bit_cnt     <= '0;
            o_spi_miso    <= w_vis[31];
            o_spi_miso_oe <= 1'b1;
            o_busy        <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_cs_rise) begin
            r_state       <= ST_IDLE;
            o_spi_miso    <= 1'b0;
            o_spi_miso_oe <= 1'b0;
            o_busy        <= 1'b0;
            o_frame_done  <= (r_bit_cnt == 6'd32);
            o_frame_abort <= (r_bit_cnt != 6'd32);
          end else if (w_sck_fall) begin
            // Zeros shift in, so MISO naturally reads 0 once all 32 bits are out.
            r_sr       <= {r_sr[30:0], 1'b0};
            o_spi_miso <= r_sr[30];
            if (r_bit_cnt != 6'd32) begin
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_max31855_emu.sv
// Directed self-checking bench for max31855_emu acting as an SPI mode-0 master.
module tb_max31855_emu;
  localparam int CONV = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs = 1'b1;
  logic [13:0] tc = '0;
  logic [11:0] ic = '0;
  logic        f_oc = 1'b0, f_scg = 1'b0, f_scv = 1'b0;
  logic        load = 1'b0;
  logic        miso, oe, busy, done, abort;

  int n_checks = 0;
  int n_fail = 0;

  max31855_emu #(.CONV_CYCLES(CONV)) dut (
    .i_sysclk(clk), .i_sysrst_n(rst_n), .i_spi_clk(sclk), .i_spi_cs(cs),
    .o_spi_miso(miso), .o_spi_miso_oe(oe),
    .i_temperature_tc(tc), .i_temperature_ic(ic),
    .i_fault_oc(f_oc), .i_fault_scg(f_scg), .i_fault_scv(f_scv),
    .i_load(load), .o_busy(busy), .o_frame_done(done), .o_frame_abort(abort)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [13:0] t, input logic [11:0] c, input logic oc_f);
    tc = t; ic = c; f_oc = oc_f; f_scg = 1'b0; f_scv = 1'b0;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  // Sample MISO just before each rising SPI_CLK edge, as a mode-0 master does.
  task automatic read_bits(input int n, output logic [63:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      w = {w[62:0], miso};
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
      tick(5);
    end
  endtask

  task automatic cs_begin();
    cs = 1'b0;
    tick(6);
  endtask

  task automatic cs_finish(output int nd, output int na);
    cs = 1'b1;
    nd = 0; na = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      nd += int'(done);
      na += int'(abort);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs = 1'b1;
    tick(3);
    n_checks++;
    if ({miso, oe, busy, done, abort} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000", {miso, oe, busy, done, abort});
    end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_basic();
    logic [63:0] w;
    int nd, na;
    do_load(14'h0190, 12'h190, 1'b0);
    cs_begin();
    n_checks++;
    if ({oe, busy} !== 2'b11) begin
      n_fail++; $display("FAIL basic_oe_busy: got %b expected 11", {oe, busy});
    end
    read_bits(32, w);
    cs_finish(nd, na);
    n_checks++;
    if (w[31:0] !== 32'h06401900) begin
      n_fail++; $display("FAIL basic_word: got %h expected 06401900", w[31:0]);
    end
    n_checks++;
    if (nd !== 1 || na !== 0) begin
      n_fail++; $display("FAIL basic_pulses: done %0d abort %0d expected 1 0", nd, na);
    end
    n_checks++;
    if ({busy, oe} !== 2'b00) begin
      n_fail++; $display("FAIL basic_idle: busy/oe got %b expected 00", {busy, oe});
    end
  endtask

  task automatic test_fault();
    logic [63:0] w;
    int nd, na;
    do_load(14'h0190, 12'h190, 1'b1);
    cs_begin();
    read_bits(32, w);
    cs_finish(nd, na);
    n_checks++;
    if (w[31:0] !== 32'h06411901) begin
      n_fail++; $display("FAIL fault_word: got %h expected 06411901", w[31:0]);
    end
    n_checks++;
    if (nd !== 1) begin
      n_fail++; $display("FAIL fault_done: got %0d expected 1", nd);
    end
  endtask

  task automatic test_abort();
    logic [63:0] w;
    int nd, na;
    cs_begin();
    read_bits(10, w);
    cs = 1'b1;
    nd = 0; na = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      nd += int'(done);
      na += int'(abort);
      if (i == 3) begin
        n_checks++;
        if (oe !== 1'b0) begin
          n_fail++; $display("FAIL abort_oe: got %b expected 0 three cycles after CS rise", oe);
        end
      end
    end
    n_checks++;
    if (na !== 1 || nd !== 0) begin
      n_fail++; $display("FAIL abort_pulses: abort %0d done %0d expected 1 0", na, nd);
    end
  endtask

  task automatic test_long();
    logic [63:0] w;
    int nd, na;
    cs_begin();
    read_bits(40, w);
    cs_finish(nd, na);
    n_checks++;
    if (w[39:8] !== 32'h06411901) begin
      n_fail++; $display("FAIL long_word: got %h expected 06411901", w[39:8]);
    end
    n_checks++;
    if (w[7:0] !== 8'h00) begin
      n_fail++; $display("FAIL long_tail: got %h expected 00", w[7:0]);
    end
    n_checks++;
    if (nd !== 1) begin
      n_fail++; $display("FAIL long_done: got %0d expected 1", nd);
    end
  endtask

  task automatic test_midload();
    logic [63:0] w1, w2;
    logic [31:0] word;
    int nd, na;
    do_load(14'h0010, 12'h000, 1'b0);
    cs_begin();
    read_bits(10, w1);
    do_load(14'h0190, 12'h190, 1'b0);
    read_bits(22, w2);
    cs_finish(nd, na);
    word = {w1[9:0], w2[21:0]};
    n_checks++;
    if (word !== 32'h00400000) begin
      n_fail++; $display("FAIL midload_current: got %h expected 00400000", word);
    end
    cs_begin();
    read_bits(32, w1);
    cs_finish(nd, na);
    n_checks++;
    if (w1[31:0] !== 32'h06401900) begin
      n_fail++; $display("FAIL midload_next: got %h expected 06401900", w1[31:0]);
    end
  endtask

  // LOAD coincides with the cycle the CS falling edge is acted on.
  task automatic test_same_cycle_load();
    logic [63:0] w;
    int nd, na;
    cs = 1'b0;
    tick(2);
    tc = 14'h0010; ic = 12'h000; f_oc = 1'b0;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(3);
    read_bits(32, w);
    cs_finish(nd, na);
    n_checks++;
    if (w[31:0] !== 32'h06401900) begin
      n_fail++; $display("FAIL same_cycle_frame: got %h expected 06401900", w[31:0]);
    end
    cs_begin();
    read_bits(32, w);
    cs_finish(nd, na);
    n_checks++;
    if (w[31:0] !== 32'h00400000) begin
      n_fail++; $display("FAIL same_cycle_next: got %h expected 00400000", w[31:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] w;
    int nd, na, np;
    do_load(14'h0190, 12'h190, 1'b1);
    cs_begin();
    read_bits(12, w);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    np = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      np += int'(done) + int'(abort);
    end
    n_checks++;
    if (np !== 0) begin
      n_fail++; $display("FAIL rstmid_pulse: got %0d pulses expected 0", np);
    end
    read_bits(4, w);
    n_checks++;
    if ({oe, busy} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_no_frame: oe/busy got %b expected 00", {oe, busy});
    end
    do_load(14'h0190, 12'h190, 1'b0);
    cs = 1'b1;
    tick(6);
    cs_begin();
    n_checks++;
    if (oe !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_restart_oe: got %b expected 1", oe);
    end
    read_bits(32, w);
    cs_finish(nd, na);
    n_checks++;
    if (w[31:0] !== 32'h06401900 || nd !== 1) begin
      n_fail++; $display("FAIL rstmid_restart: word %h done %0d expected 06401900 1", w[31:0], nd);
    end
  endtask

  task automatic test_conv();
    logic [63:0] w;
    int nd, na;
    do_load(14'h0010, 12'h000, 1'b0);
    tick(150);
    cs_begin();
    read_bits(32, w);
    cs_finish(nd, na);
    n_checks++;
    if (w[31:0] !== 32'h00400000) begin
      n_fail++; $display("FAIL conv_first: got %h expected 00400000", w[31:0]);
    end
    do_load(14'h0190, 12'h190, 1'b0);
    tick(40);
    cs_begin();
    read_bits(32, w);
    cs_finish(nd, na);
    n_checks++;
    if (w[31:0] !== 32'h00400000) begin
      n_fail++; $display("FAIL conv_early: got %h expected 00400000", w[31:0]);
    end
    tick(140);
    cs_begin();
    read_bits(32, w);
    cs_finish(nd, na);
    n_checks++;
    if (w[31:0] !== 32'h06401900) begin
      n_fail++; $display("FAIL conv_late: got %h expected 06401900", w[31:0]);
    end
  endtask

  initial begin
    test_reset();
`ifdef MAX31855_EMU_CONV_EN
    test_conv();
`else
    test_basic();
    test_fault();
    test_abort();
    test_long();
    test_midload();
    test_same_cycle_load();
    test_reset_mid_frame();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/max31855_emu.md
MAX31855_EMU -- requirements
Module: max31855_emu

Interface
REQ-001 Parameter: CONV_CYCLES, default 1000, SYSCLK cycles of emulated conversion time (range 1..1048575, 20-bit counter).
REQ-002 SYSCLK  input  1  sole clock; all logic on rising edge.
REQ-003 SYSRST_N  input  1  reset, synchronous, active-low.
REQ-004 SPI_CLK  input  1  serial clock from external master, asynchronous to SYSCLK.
REQ-005 SPI_CS  input  1  chip select from master, active-low, asynchronous.
REQ-006 SPI_MISO  output  1  serial data to master, MSB first.
REQ-007 SPI_MISO_OE  output  1  MISO drive enable; 0 = high-Z at pad.
REQ-008 TEMPERATURE_TC  input  14  thermocouple value, signed, 0.25 C/LSB.
REQ-009 TEMPERATURE_IC  input  12  cold-junction value, signed, 0.0625 C/LSB.
REQ-010 FAULT_OC, FAULT_SCG, FAULT_SCV  input  1 each  fault flags.
REQ-011 LOAD  input  1  one-cycle strobe capturing REQ-008..010 into the pending register.
REQ-012 BUSY  output  1  high while a frame is active.
REQ-013 FRAME_DONE  output  1  one-cycle pulse: CS rose after >=32 bits shifted.
REQ-014 FRAME_ABORT  output  1  one-cycle pulse: CS rose after <32 bits shifted.

Function
REQ-015 SPI_CS and SPI_CLK SHALL pass through 2-flop synchronizers plus one edge-detect flop; edge events act 3 SYSCLK cycles after the pin edge.
REQ-016 Master SPI_CLK high and low phases SHALL each be >=4 SYSCLK cycles; shorter phases are unsupported.
REQ-017 Frame word SHALL be: [31:18] TC, [17] 0, [16] OR of faults, [15:4] IC, [3] 0, [2] SCV, [1] SCG, [0] OC.
REQ-018 LOAD SHALL capture into pending on any cycle, including mid-frame; it never alters an active frame.
REQ-019 States IDLE, SHIFT: CS falling edge in IDLE -> SHIFT, shift register loaded from visible data, OE=1, MISO=bit 31, bit counter=0.
REQ-020 In SHIFT, each SPI_CLK falling edge SHALL shift left one bit and increment the counter; counter saturates at 32.
REQ-021 After 32 falling edges MISO SHALL be 0 until CS rises.
REQ-022 SPI_CLK edges in IDLE SHALL be ignored.
REQ-023 CS rising edge in SHIFT -> IDLE, OE=0, MISO=0, and pulse FRAME_DONE (counter=32) or FRAME_ABORT (counter<32).
REQ-024 LOAD in the same cycle as CS falling-edge detect SHALL NOT appear in that frame.
REQ-025 BUSY SHALL equal (state==SHIFT).

Reset
REQ-026 On SYSRST_N low at a SYSCLK edge: state IDLE, MISO=0, OE=0, BUSY=0, FRAME_DONE=0, FRAME_ABORT=0, shift/pending/visible registers 0, counters 0.
REQ-027 Synchronizer flops SHALL reset to 0, so CS held low through reset release starts no frame; a CS high-then-low sequence is required.
REQ-028 Reset mid-frame SHALL abort silently, with no FRAME_ABORT pulse.

Configuration
REQ-029 Macro MAX31855_EMU_CONV_EN defined: visible data updates from pending only when a conversion completes.
REQ-029a A conversion starts on each CS rising edge and completes CONV_CYCLES SYSCLK cycles later.
REQ-029b A CS falling edge during a conversion cancels it; the frame carries the last completed data.
REQ-029c Out of reset the first conversion starts immediately.
REQ-030 Macro undefined: visible data SHALL track pending continuously, with no conversion counter and zero added latency.

Verification
REQ-031 LOAD TC=14'h0190, IC=12'h190, faults 0; CS low; 32 clocks -> master reads 32'h06401900; FRAME_DONE pulses once; BUSY low after CS rise.
REQ-032 Same values plus FAULT_OC=1 -> 32'h06411901.
REQ-033 CS low, 10 clocks, CS high -> FRAME_ABORT pulse, FRAME_DONE stays 0, OE=0 within 3 cycles.
REQ-034 40 clocks in one frame -> bits 33..40 read 0; FRAME_DONE pulses.
REQ-035 LOAD 14'h0190 mid-frame -> current frame unchanged; next frame carries the new value (CONV_EN undefined); with CONV_EN and CONV_CYCLES=100, a frame started 50 cycles after CS rise returns old data and one started 150 cycles after returns new data.
REQ-036 SYSRST_N low at bit 12 with CS held low -> OE=0, no pulse, no frame until CS cycles high then low.
